// File: rtl/elastic_config_loader_pkg.sv
// Shared sizes, config-entry layout and loader state encoding for the
// elastic configuration loader and its PE-array-facing buses.
package elastic_config_loader_pkg;

   localparam int PE_NUM                  = 16;
   localparam int CONTEXT_SIZE            = 16;
   localparam int CONTEXT_SIZE_BIT_LENGTH = 4;
   localparam int PE_INDEX_BIT_LENGTH     = 4;
   localparam int DATA_WIDTH              = 32;
   localparam int OPERATION_BIT_LENGTH    = 4;
   localparam int INPUT_NUM_BIT_LENGTH    = 3;
   localparam int NEIGHBOR_PE_NUM         = 4;

   // The host may request a max id beyond the context memory; one extra bit
   // lets the loader see such requests and clamp them instead of wrapping.
   localparam int MAX_ID_IN_BITS = CONTEXT_SIZE_BIT_LENGTH + 1;

   // One context-memory entry as written into a PE.
   typedef struct packed {
      logic [INPUT_NUM_BIT_LENGTH-1:0] input_PE_index_1;
      logic [INPUT_NUM_BIT_LENGTH-1:0] input_PE_index_2;
      logic [NEIGHBOR_PE_NUM-1:0]      output_PE_index;
      logic [OPERATION_BIT_LENGTH-1:0] op;
      logic [DATA_WIDTH-1:0]           const_data;
   } ElasticConfigData;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_START = 2'd2,
      ST_RUN   = 2'd3
   } loader_state_e;

endpackage

// File: rtl/elastic_config_loader_if.sv
// Entry stream (valid/stop handshake) from the host side, and the broadcast
// configuration bus towards the PE array.
interface elastic_entry_if;
   import elastic_config_loader_pkg::*;

   logic             valid_input;
   logic             stop_input;
   ElasticConfigData data;

   modport master (output valid_input, output data, input stop_input);
   modport slave  (input valid_input, input data, output stop_input);
endinterface

interface elastic_config_if #(parameter int PE_N = elastic_config_loader_pkg::PE_NUM);
   import elastic_config_loader_pkg::*;

   logic [PE_N-1:0]                    write_config_data;
   ElasticConfigData                   config_data;
   logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index;
   logic                               start_exec;
   logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id;

   modport master (output write_config_data, output config_data, output config_index,
                   output start_exec, output mapping_context_max_id);
   modport slave  (input write_config_data, input config_data, input config_index,
                   input start_exec, input mapping_context_max_id);
endinterface

// File: rtl/elastic_config_loader_config_entry_counter.sv
// PE-major (pe, ctx) position counter: ctx runs 0..max, then pe advances.
// last_entry flags the final slot of the final PE.
module config_entry_counter
   import elastic_config_loader_pkg::*;
#(
   parameter int P_PE_NUM      = PE_NUM,
   parameter int P_PE_IDX_BITS = PE_INDEX_BIT_LENGTH
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               i_clear,
   input  logic                               i_advance,
   input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] i_max,
   output logic [P_PE_IDX_BITS-1:0]           o_pe_cnt,
   output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] o_ctx_cnt,
   output logic                               o_last_entry
);

   logic [P_PE_IDX_BITS-1:0]           r_pe_cnt;
   logic [CONTEXT_SIZE_BIT_LENGTH-1:0] r_ctx_cnt;
   logic                               w_ctx_wrap;

   assign w_ctx_wrap   = (r_ctx_cnt == i_max);
   // Compare against the real last PE, not the all-ones counter value.
   assign o_last_entry = w_ctx_wrap && (r_pe_cnt == P_PE_IDX_BITS'(P_PE_NUM - 1));
   assign o_pe_cnt     = r_pe_cnt;
   assign o_ctx_cnt    = r_ctx_cnt;

   // Restart on a new load; otherwise step once per accepted entry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pe_cnt  <= '0;
         r_ctx_cnt <= '0;
      end else if (i_clear) begin
         r_pe_cnt  <= '0;
         r_ctx_cnt <= '0;
      end else if (i_advance) begin
         if (w_ctx_wrap) begin
            r_ctx_cnt <= '0;
            r_pe_cnt  <= r_pe_cnt + 1'b1;
         end else begin
            r_ctx_cnt <= r_ctx_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/elastic_config_loader.sv
// Streams config entries into the PE array's context memories, one PE-slot
// per accepted entry, then pulses start_exec once the last write has landed.
module elastic_config_loader
   import elastic_config_loader_pkg::*;
#(
   parameter int P_PE_NUM      = PE_NUM,
   parameter int P_PE_IDX_BITS = PE_INDEX_BIT_LENGTH
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      load_request,
   input  logic [MAX_ID_IN_BITS-1:0] context_max_id,
   elastic_entry_if.slave            entry_if,
   elastic_config_if.master          cfg_if,
   output logic                      busy,
   output logic                      done,
   output logic                      cfg_error
);

   loader_state_e                      r_state;
   loader_state_e                      w_state_next;
   logic [P_PE_NUM-1:0]                r_write;
   ElasticConfigData                   r_data;
   logic [CONTEXT_SIZE_BIT_LENGTH-1:0] r_index;
   logic                               r_start_exec;
   logic [CONTEXT_SIZE_BIT_LENGTH-1:0] r_max;
   logic                               r_cfg_error;

   logic                               w_load_accept;
   logic                               w_entry_accept;
   logic                               w_clamped;
   logic [CONTEXT_SIZE_BIT_LENGTH-1:0] w_max_clamped;
   logic [P_PE_IDX_BITS-1:0]           w_pe_cnt;
   logic [CONTEXT_SIZE_BIT_LENGTH-1:0] w_ctx_cnt;
   logic                               w_last_entry;

   assign w_load_accept  = load_request && (r_state == ST_IDLE || r_state == ST_RUN);
   assign w_entry_accept = entry_if.valid_input && (r_state == ST_LOAD);
   assign w_clamped      = (context_max_id > MAX_ID_IN_BITS'(CONTEXT_SIZE - 1));
   assign w_max_clamped  = w_clamped ? CONTEXT_SIZE_BIT_LENGTH'(CONTEXT_SIZE - 1)
                                     : context_max_id[CONTEXT_SIZE_BIT_LENGTH-1:0];

   config_entry_counter #(
      .P_PE_NUM      (P_PE_NUM),
      .P_PE_IDX_BITS (P_PE_IDX_BITS)
   ) u_counter (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_clear      (w_load_accept),
      .i_advance    (w_entry_accept),
      .i_max        (r_max),
      .o_pe_cnt     (w_pe_cnt),
      .o_ctx_cnt    (w_ctx_cnt),
      .o_last_entry (w_last_entry)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_next;
   end

   // Next-state: load_request only matters when no load is in flight.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_load_accept) w_state_next = ST_LOAD;
         ST_LOAD:  if (w_entry_accept && w_last_entry) w_state_next = ST_START;
         ST_START: w_state_next = ST_RUN;
         ST_RUN:   if (w_load_accept) w_state_next = ST_LOAD;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // Registered write strobe / payload, start pulse and latched max id.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_write      <= '0;
         r_data       <= '0;
         r_index      <= '0;
         r_start_exec <= 1'b0;
         r_max        <= '0;
         r_cfg_error  <= 1'b0;
      end else begin
         r_write      <= w_entry_accept ? (P_PE_NUM'(1) << w_pe_cnt) : '0;
         r_start_exec <= (r_state == ST_START);
         if (w_entry_accept) begin
            r_data  <= entry_if.data;
            r_index <= w_ctx_cnt;
         end
         if (w_load_accept) begin
            r_max       <= w_max_clamped;
            r_cfg_error <= w_clamped;
         end
      end
   end

   assign entry_if.stop_input           = (r_state != ST_LOAD);
   assign cfg_if.write_config_data      = r_write;
   assign cfg_if.config_data            = r_data;
   assign cfg_if.config_index           = r_index;
   assign cfg_if.start_exec             = r_start_exec;
   assign cfg_if.mapping_context_max_id = r_max;
   assign busy                          = (r_state == ST_LOAD) || (r_state == ST_START);
   assign done                          = (r_state == ST_RUN);
   assign cfg_error                     = r_cfg_error;

endmodule

// File: tb/tb_elastic_config_loader.sv
// Directed bench for elastic_config_loader with a 4-PE array.
module tb_elastic_config_loader;
   import elastic_config_loader_pkg::*;

   localparam int TB_PE      = 4;
   localparam int TB_PE_BITS = 2;

   logic                      clk = 1'b0;
   logic                      reset_n;
   logic                      load_request;
   logic [MAX_ID_IN_BITS-1:0] context_max_id;
   logic                      busy;
   logic                      done;
   logic                      cfg_error;

   int checks    = 0;
   int errors    = 0;
   int wr_count  = 0;

   elastic_entry_if                     u_entry ();
   elastic_config_if #(.PE_N(TB_PE))    u_cfg ();

   elastic_config_loader #(
      .P_PE_NUM      (TB_PE),
      .P_PE_IDX_BITS (TB_PE_BITS)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .load_request   (load_request),
      .context_max_id (context_max_id),
      .entry_if       (u_entry),
      .cfg_if         (u_cfg),
      .busy           (busy),
      .done           (done),
      .cfg_error      (cfg_error)
   );

   always #5 clk = ~clk;

   // Count strobe cycles independently of the directed checks.
   always @(negedge clk) begin
      if (u_cfg.write_config_data != '0) wr_count++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entry payload for the n-th entry of a load; entry 2 is a fixed pattern.
   function automatic ElasticConfigData entry_for(input int n);
      ElasticConfigData e;
      if (n == 2) begin
         e.input_PE_index_1 = 3'd5;
         e.input_PE_index_2 = 3'd6;
         e.output_PE_index  = 4'b1010;
         e.op               = 4'd3;
         e.const_data       = 32'hDEADBEEF;
      end else begin
         e.input_PE_index_1 = 3'(n);
         e.input_PE_index_2 = 3'(n + 1);
         e.output_PE_index  = 4'(n * 3);
         e.op               = 4'(n + 7);
         e.const_data       = 32'h1000_0000 + 32'(n);
      end
      return e;
   endfunction

   // One complete load. gap=1 toggles valid 1,0,1,0; pulse_at>=0 raises
   // load_request (with a different max id) on that cycle of the load.
   task automatic run_load(input int m_in, input int gap, input int pulse_at);
      int m;
      int total;
      int base;
      int pe;
      int ctx;
      int n;
      int cyc;
      logic v;
      ElasticConfigData last_e;
      m     = (m_in > CONTEXT_SIZE - 1) ? CONTEXT_SIZE - 1 : m_in;
      total = TB_PE * (m + 1);
      base  = wr_count;
      load_request   = 1'b1;
      context_max_id = MAX_ID_IN_BITS'(m_in);
      tick();
      load_request = 1'b0;
      check("load_busy", 64'(busy), 64'd1);
      check("load_done", 64'(done), 64'd0);
      check("load_stop", 64'(u_entry.stop_input), 64'd0);
      check("load_maxid", 64'(u_cfg.mapping_context_max_id), 64'(m));
      check("load_cfgerr", 64'(cfg_error), 64'(m_in > CONTEXT_SIZE - 1));
      pe = 0; ctx = 0; n = 0; cyc = 0;
      last_e = '0;
      while (n < total && cyc < 400) begin
         v = (gap == 0) ? 1'b1 : ((cyc % 2) == 0);
         u_entry.valid_input = v;
         u_entry.data        = entry_for(n);
         load_request        = (cyc == pulse_at);
         context_max_id      = (cyc == pulse_at) ? MAX_ID_IN_BITS'(5) : MAX_ID_IN_BITS'(m_in);
         tick();
         cyc++;
         load_request = 1'b0;
         if (v) begin
            last_e = entry_for(n);
            check("strobe", 64'(u_cfg.write_config_data), 64'(1) << pe);
            check("index", 64'(u_cfg.config_index), 64'(ctx));
            check("data", 64'(u_cfg.config_data), 64'(last_e));
            $display("load max=%0d entry %0d: strobe=%b ctx=%0d const=%h", m, n,
                     u_cfg.write_config_data, u_cfg.config_index, u_cfg.config_data.const_data);
            if (ctx == m) begin ctx = 0; pe++; end
            else ctx++;
            n++;
         end else begin
            check("gap_strobe", 64'(u_cfg.write_config_data), 64'd0);
            check("gap_hold", 64'(u_cfg.config_data), 64'(last_e));
         end
      end
      u_entry.valid_input = 1'b0;
      if (n < total) check("entry_timeout", 64'(n), 64'(total));
      check("start_stop", 64'(u_entry.stop_input), 64'd1);
      check("start_exec_early", 64'(u_cfg.start_exec), 64'd0);
      tick();
      check("start_exec", 64'(u_cfg.start_exec), 64'd1);
      check("post_strobe", 64'(u_cfg.write_config_data), 64'd0);
      tick();
      check("start_exec_once", 64'(u_cfg.start_exec), 64'd0);
      check("run_done", 64'(done), 64'd1);
      check("run_busy", 64'(busy), 64'd0);
      check("run_maxid", 64'(u_cfg.mapping_context_max_id), 64'(m));
      check("write_count", 64'(wr_count - base), 64'(total));
      $display("load max_in=%0d done: %0d writes", m_in, wr_count - base);
   endtask

   initial begin
      reset_n             = 1'b0;
      load_request        = 1'b0;
      context_max_id      = '0;
      u_entry.valid_input = 1'b0;
      u_entry.data        = '0;
      repeat (2) tick();
      check("rst_strobe", 64'(u_cfg.write_config_data), 64'd0);
      check("rst_index", 64'(u_cfg.config_index), 64'd0);
      check("rst_data", 64'(u_cfg.config_data), 64'd0);
      check("rst_start", 64'(u_cfg.start_exec), 64'd0);
      check("rst_maxid", 64'(u_cfg.mapping_context_max_id), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_cfgerr", 64'(cfg_error), 64'd0);
      check("rst_stop", 64'(u_entry.stop_input), 64'd1);
      reset_n = 1'b1;
      tick();

      // Abort a load after 5 accepts with an asynchronous reset.
      load_request   = 1'b1;
      context_max_id = MAX_ID_IN_BITS'(1);
      tick();
      load_request        = 1'b0;
      u_entry.valid_input = 1'b1;
      for (int i = 0; i < 5; i++) begin
         u_entry.data = entry_for(i);
         tick();
      end
      check("mid_stop", 64'(u_entry.stop_input), 64'd0);
      #2 reset_n = 1'b0;
      #1;
      check("abort_strobe", 64'(u_cfg.write_config_data), 64'd0);
      check("abort_stop", 64'(u_entry.stop_input), 64'd1);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_maxid", 64'(u_cfg.mapping_context_max_id), 64'd0);
      check("abort_data", 64'(u_cfg.config_data), 64'd0);
      $display("reset during load: stop=%b busy=%b", u_entry.stop_input, busy);
      u_entry.valid_input = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();

      run_load(1, 0, -1);   // restarts from PE0/ctx0, 8 back-to-back writes
      run_load(1, 1, -1);   // valid toggling 1,0,1,0
      run_load(31, 0, -1);  // clamped to 15: 64 writes, cfg_error set
      run_load(1, 0, 3);    // load_request mid-load ignored
      run_load(0, 0, -1);   // from RUN, max 0: 4 writes, cfg_error cleared

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
